regfile: RTL



---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_if.sv | 29 ++
 rtl/regfile_rd_port.sv | 30 +++
 rtl/regfile.sv | 83 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the rv32i register file slice.
package regfile_pkg;
  localparam int           REG_NUM          = 32;
  localparam int           DEF_DATA_WIDTH   = 32;
  localparam int           DEF_RADDR_WIDTH  = 5;
  localparam logic         REG_WR_EN        = 1'b1;
  localparam logic         REG_WR_DIS       = 1'b0;
  localparam logic [4:0]   R_ZERO           = 5'd0;
  localparam logic [31:0]  ZERO             = 32'h0;
endpackage

// File: rtl/regfile_if.sv
// Bus between writeback/decode/debug and the register file.
// dbg_ren is a one-cycle request with no backpressure; every request is
// answered by dbg_rvalid high for exactly one cycle, one cycle later.
interface regfile_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
);
  logic                   reg_write;
  logic [RADDR_WIDTH-1:0] reg_waddr;
  logic [DATA_WIDTH-1:0]  reg_wdata;
  logic [RADDR_WIDTH-1:0] rs1_raddr;
  logic [DATA_WIDTH-1:0]  rs1_rdata;
  logic [RADDR_WIDTH-1:0] rs2_raddr;
  logic [DATA_WIDTH-1:0]  rs2_rdata;
  logic                   dbg_ren;
  logic [RADDR_WIDTH-1:0] dbg_raddr;
  logic [DATA_WIDTH-1:0]  dbg_rdata;
  logic                   dbg_rvalid;

  modport master (
    output reg_write, reg_waddr, reg_wdata, rs1_raddr, rs2_raddr, dbg_ren, dbg_raddr,
    input  rs1_rdata, rs2_rdata, dbg_rdata, dbg_rvalid
  );

  modport slave (
    input  reg_write, reg_waddr, reg_wdata, rs1_raddr, rs2_raddr, dbg_ren, dbg_raddr,
    output rs1_rdata, rs2_rdata, dbg_rdata, dbg_rvalid
  );
endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: x0 check, optional write-first bypass, storage mux.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RADDR_WIDTH = DEF_RADDR_WIDTH,
  parameter bit BYPASS_EN   = 1'b1
) (
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  regs [1:REG_NUM-1],
  input  logic                   reg_write,
  input  logic [RADDR_WIDTH-1:0] reg_waddr,
  input  logic [DATA_WIDTH-1:0]  reg_wdata,
  input  logic [RADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);

  // Reset gates the bypass too, so a pending write cannot leak out while held.
  always_comb begin
    rdata = '0;
    if (!rst_n || raddr == R_ZERO) begin
      rdata = '0;
    end else if (BYPASS_EN && reg_write == REG_WR_EN && reg_waddr == raddr) begin
      rdata = reg_wdata;
    end else begin
      rdata = regs[raddr];
    end
  end

endmodule

// File: rtl/regfile.sv
// 32-entry rv32i register file: one write port, two combinational read ports,
// and a registered debug read port.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RADDR_WIDTH = DEF_RADDR_WIDTH,
  parameter bit BYPASS_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_if.slave   bus
);

  logic [DATA_WIDTH-1:0] regs [1:REG_NUM-1];
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] dbg_next;

  assign wr_commit = (bus.reg_write == REG_WR_EN) && (bus.reg_waddr != R_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[bus.reg_waddr] <= bus.reg_wdata;
    end
  end

  regfile_rd_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RADDR_WIDTH (RADDR_WIDTH),
    .BYPASS_EN   (BYPASS_EN)
  ) u_rs1 (
    .rst_n     (rst_n),
    .regs      (regs),
    .reg_write (bus.reg_write),
    .reg_waddr (bus.reg_waddr),
    .reg_wdata (bus.reg_wdata),
    .raddr     (bus.rs1_raddr),
    .rdata     (bus.rs1_rdata)
  );

  regfile_rd_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RADDR_WIDTH (RADDR_WIDTH),
    .BYPASS_EN   (BYPASS_EN)
  ) u_rs2 (
    .rst_n     (rst_n),
    .regs      (regs),
    .reg_write (bus.reg_write),
    .reg_waddr (bus.reg_waddr),
    .reg_wdata (bus.reg_wdata),
    .raddr     (bus.rs2_raddr),
    .rdata     (bus.rs2_rdata)
  );

  // Debug returns post-edge state, so a same-edge write is always forwarded here.
  always_comb begin
    dbg_next = '0;
    if (bus.dbg_raddr == R_ZERO) begin
      dbg_next = '0;
    end else if (wr_commit && bus.reg_waddr == bus.dbg_raddr) begin
      dbg_next = bus.reg_wdata;
    end else begin
      dbg_next = regs[bus.dbg_raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dbg_rdata  <= '0;
      bus.dbg_rvalid <= 1'b0;
    end else begin
      bus.dbg_rvalid <= bus.dbg_ren;
      if (bus.dbg_ren) begin
        bus.dbg_rdata <= dbg_next;
      end
    end
  end

endmodule
